// File: rtl/acc_bcd_converter_if.sv
// Handshake and result bundle for the
// accumulator binary-to-BCD converter.
interface acc_bcd_converter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [3:0]       bcd_hundreds;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_hundreds,
    input  bcd_tens,
    input  bcd_ones
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_hundreds,
    output bcd_tens,
    output bcd_ones
  );
endinterface

// File: rtl/acc_bcd_converter.sv
// Sequential double-dabble converter: one
// shift-add-3 iteration per clock.
module acc_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic Clock,
  input logic Reset_b,
  acc_bcd_converter_if.slave bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   res_q, res_d;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   scr_nx;

  // Add-3 correction, then the combined left shift
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_nx = {adj[SW-2:0], shift_q[WIDTH-1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.bin_in;
          scr_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d   = scr_nx;
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = scr_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, sync reset
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy         = (state_q == SHIFT);
  assign bus.done         = (state_q == DONE);
  assign bus.bcd_ones     = res_q[3:0];
  assign bus.bcd_tens     = res_q[7:4];
  assign bus.bcd_hundreds = res_q[11:8];

endmodule

// File: tb/tb_acc_bcd_converter.sv
// Self-checking bench: decimal reference model
// plus directed vectors with literal results.
module tb_acc_bcd_converter;

  localparam int WIDTH = 8;

  logic Clock;
  logic Reset_b;

  acc_bcd_converter_if #(.WIDTH(WIDTH)) bus();

  acc_bcd_converter #(
    .WIDTH(WIDTH),
    .DIGITS(3)
  ) dut (
    .Clock(Clock),
    .Reset_b(Reset_b),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  int m_left = 0;
  int m_done = 0;
  int m_disp = 0;
  int m_pend = 0;

  initial Clock = 0;
  always #5 Clock = ~Clock;

  // Reference model: a conversion is a WIDTH-cycle
  // busy window, then the decimal value appears.
  always @(posedge Clock) begin
    if (!Reset_b) begin
      m_left <= 0;
      m_done <= 0;
      m_disp <= 0;
    end else if (m_done != 0) begin
      m_done <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_disp <= m_pend;
        m_done <= 1;
      end
    end else if (bus.start) begin
      m_pend <= int'(bus.bin_in);
      m_left <= WIDTH;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clock) begin
    if (chk_en) begin
      int eh, et, eo;
      logic eb, ed;
      eh = m_disp / 100;
      et = (m_disp / 10) % 10;
      eo = m_disp % 10;
      eb = (m_left > 0);
      ed = (m_done != 0);
      checks++;
      if (bus.busy !== eb || bus.done !== ed ||
          bus.bcd_hundreds !== 4'(eh) ||
          bus.bcd_tens !== 4'(et) ||
          bus.bcd_ones !== 4'(eo)) begin
        errors++;
        $display("FAIL model t=%0t got b%b d%b %0d/%0d/%0d want b%b d%b %0d/%0d/%0d",
                 $time, bus.busy, bus.done,
                 bus.bcd_hundreds, bus.bcd_tens,
                 bus.bcd_ones, eb, ed, eh, et, eo);
      end
    end
  end

  task automatic chk(input string nm,
                     input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, got, exp);
    end
  endtask

  task automatic chk_bcd(input string nm,
                         input int h,
                         input int t,
                         input int o);
    chk({nm, "_h"}, int'(bus.bcd_hundreds), h);
    chk({nm, "_t"}, int'(bus.bcd_tens), t);
    chk({nm, "_o"}, int'(bus.bcd_ones), o);
  endtask

  // Start one conversion from IDLE; returns the
  // acceptance-to-done latency, leaves FSM in IDLE.
  task automatic convert(input logic [7:0] v,
                         output int lat);
    bus.bin_in = v;
    bus.start  = 1'b1;
    lat = 0;
    @(negedge Clock);
    bus.start = 1'b0;
    while (!bus.done && lat < 30) begin
      @(negedge Clock);
      lat++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL timeout got no done want done");
    end
    @(negedge Clock);
  endtask

  initial begin
    int lat, nd, prev, val;
    Reset_b    = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;

    // 1: reset and idle
    @(negedge Clock);
    chk_en = 1;
    @(negedge Clock);
    Reset_b = 1'b1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk_bcd("rst", 0, 0, 0);
    repeat (10) @(negedge Clock);
    chk_bcd("idle", 0, 0, 0);

    // 2: directed values
    convert(8'hFF, lat);
    chk("lat_ff", lat, 8);
    chk_bcd("ff", 2, 5, 5);
    convert(8'h00, lat);
    chk_bcd("00", 0, 0, 0);
    convert(8'hAB, lat);
    chk_bcd("ab", 1, 7, 1);
    convert(8'h09, lat);
    chk_bcd("09", 0, 0, 9);

    // 3: start and bin_in changes during SHIFT
    bus.bin_in = 8'h64;
    bus.start  = 1'b1;
    @(negedge Clock);
    bus.start = 1'b0;
    repeat (2) @(negedge Clock);
    bus.bin_in = 8'hFF;
    bus.start  = 1'b1;
    @(negedge Clock);
    bus.start = 1'b0;
    @(negedge Clock);
    bus.start = 1'b1;
    @(negedge Clock);
    bus.start = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge Clock);
      if (bus.done) nd++;
    end
    chk("iso_dones", nd, 1);
    chk_bcd("iso", 1, 0, 0);

    // 4: reset aborts a conversion
    convert(8'd42, lat);
    chk_bcd("pre", 0, 4, 2);
    bus.bin_in = 8'hC8;
    bus.start  = 1'b1;
    @(negedge Clock);
    bus.start = 1'b0;
    repeat (3) @(negedge Clock);
    Reset_b = 1'b0;
    @(negedge Clock);
    Reset_b = 1'b1;
    chk("abort_busy", int'(bus.busy), 0);
    chk_bcd("abort", 0, 0, 0);
    nd = 0;
    repeat (12) begin
      @(negedge Clock);
      if (bus.done) nd++;
    end
    chk("abort_dones", nd, 0);

    // 5: start held high retriggers
    bus.bin_in = 8'h7F;
    bus.start  = 1'b1;
    nd = 0;
    prev = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge Clock);
      if (bus.done) begin
        nd++;
        if (prev >= 0) chk("period", i - prev, 10);
        chk_bcd("hold", 1, 2, 7);
        prev = i;
      end
    end
    chk("hold_dones", nd, 4);
    bus.start = 1'b0;
    repeat (12) @(negedge Clock);

    // 6: exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), lat);
      chk("sw_lat", lat, 8);
      val = 100 * int'(bus.bcd_hundreds) +
            10 * int'(bus.bcd_tens) +
            int'(bus.bcd_ones);
      chk("sw_val", val, v);
      checks++;
      if (bus.bcd_hundreds > 4'd9 ||
          bus.bcd_tens > 4'd9 ||
          bus.bcd_ones > 4'd9) begin
        errors++;
        $display("FAIL sw_digit got %0d/%0d/%0d want each <=9",
                 bus.bcd_hundreds, bus.bcd_tens,
                 bus.bcd_ones);
      end
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
